// File: rtl/pr3_phase_scanner.sv
// pr3_phase_scanner: multi-channel single-bin DFT phase meter with a swept bin.
// Each frame correlates 2^FFT samples per channel against bin k, resolves each
// channel angle with a sequential CORDIC and reports ch1/ch2 phase relative to ch0.
// Optional feature macro: PR3_MAG_GATE_EN (zero the phases when channel 0 is near silent).
module pr3_phase_scanner #(
    parameter int NSINK = 3,
    parameter int WIDTH = 14,
    parameter int FFT   = 11,
    parameter int FREQ  = 5000,
    parameter int KMIN  = 100,
    parameter int KMAX  = 107
) (
    input  logic                    clk40,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] sink [NSINK],
    output logic                    source_valid,
    output logic                    source_sop,
    output logic                    source_eop,
    output logic [23:0]             source_freq,
    output logic [15:0]             source_phaseA,
    output logic [15:0]             source_phaseB
);

    localparam int unsigned CLK_HZ = 40_000_000;
    localparam int unsigned N      = 1 << FFT;
    localparam int unsigned QN     = N / 4;
    localparam int unsigned P      = CLK_HZ / FREQ;
    localparam int unsigned FCW    = $clog2(P);
    localparam int unsigned PW     = WIDTH + 16;
    localparam int unsigned ACCW   = WIDTH + 16 + FFT;
    localparam int unsigned AW1    = ACCW + 1;
    localparam int unsigned AW2    = ACCW + 2;
    localparam int unsigned LW     = $clog2(AW1);
    localparam int unsigned RW     = FFT - 1;
    localparam int unsigned NW     = 18;
    localparam int unsigned CW     = 20;
    localparam int unsigned CHW    = $clog2(NSINK);
    localparam real         PI     = 3.14159265358979323846;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER} state_e;

    // Quarter-wave sine ROM (0..pi/2 inclusive) and CORDIC arctangent table, 2^16 = 2*pi.
    logic signed [15:0] rom [QN+1];
    logic        [15:0] atan_t [16];

    for (genvar gi = 0; gi <= QN; gi++) begin : g_rom
        localparam int VAL = $rtoi(32767.0 * $sin(PI * 0.5 * $itor(gi) / $itor(QN)) + 0.5);
        assign rom[gi] = 16'(VAL);
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_atan
        localparam int VAL = $rtoi($atan(1.0 / $itor(1 << gi)) * 32768.0 / PI + 0.5);
        assign atan_t[gi] = 16'(VAL);
    end

    function automatic logic signed [15:0] qlook(input logic [FFT-1:0] idx);
        logic [RW-1:0]      r;
        logic signed [15:0] m;
        r = idx[FFT-2] ? (RW'(QN) - RW'(idx[FFT-3:0])) : RW'(idx[FFT-3:0]);
        m = rom[r];
        return idx[FFT-1] ? -m : m;
    endfunction

    state_e                  state_q, state_d;
    logic [FCW-1:0]          fc_q, fc_d;
    logic [FFT-1:0]          ph_q, ph_d;
    logic [FFT-1:0]          k_q, k_d;
    logic [CHW-1:0]          ch_q, ch_d;
    logic [3:0]              it_q, it_d;
    logic signed [CW-1:0]    x_q, x_d, y_q, y_d;
    logic [15:0]             z_q, z_d;
    logic                    zero_q, zero_d;
    logic signed [ACCW-1:0]  re_q [NSINK];
    logic signed [ACCW-1:0]  re_d [NSINK];
    logic signed [ACCW-1:0]  im_q [NSINK];
    logic signed [ACCW-1:0]  im_d [NSINK];
    logic [15:0]             ang_q [NSINK];
    logic [15:0]             ang_d [NSINK];
    logic                    valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [23:0]             freq_q, freq_d;
    logic [15:0]             pa_q, pa_d, pb_q, pb_d;

    logic signed [15:0]      tw_sin, tw_cos;
    logic signed [PW-1:0]    prod_re [NSINK];
    logic signed [PW-1:0]    prod_im [NSINK];
    logic [AW1-1:0]          abs_re, abs_im, mag_or;
    logic [LW-1:0]           lead, shift;
    logic signed [NW-1:0]    nre, nim;
    logic                    norm_zero;
    logic signed [CW-1:0]    xs, ys, cx, cy;
    logic [15:0]             z_n;

    // Twiddle lookup at the current phase-accumulator index and per-channel products.
    always_comb begin
        tw_sin = qlook(ph_q);
        tw_cos = qlook(ph_q + FFT'(QN));
        for (int c = 0; c < NSINK; c++) begin
            prod_re[c] = PW'(sink[c]) * PW'(tw_cos);
            prod_im[c] = PW'(sink[c]) * PW'(tw_sin);
        end
    end

    // Block-normalise the selected channel so its larger component fits 18 bits.
    always_comb begin
        abs_re = re_q[ch_q][ACCW-1] ? -AW1'(re_q[ch_q]) : AW1'(re_q[ch_q]);
        abs_im = im_q[ch_q][ACCW-1] ? -AW1'(im_q[ch_q]) : AW1'(im_q[ch_q]);
        mag_or = abs_re | abs_im;
        lead   = '0;
        for (int b = 0; b < AW1; b++) begin
            if (mag_or[b]) lead = LW'(b);
        end
        shift     = (lead > LW'(16)) ? (lead - LW'(16)) : '0;
        nre       = NW'(re_q[ch_q] >>> shift);
        nim       = NW'(im_q[ch_q] >>> shift);
        norm_zero = (mag_or == '0);
    end

`ifdef PR3_MAG_GATE_EN
    logic [AW1-1:0] g_re, g_im;
    logic [AW2-1:0] g_sum;
    logic           gate_c;

    // Channel 0 L1 magnitude below about one LSB of average amplitude suppresses the phases.
    always_comb begin
        g_re   = re_q[0][ACCW-1] ? -AW1'(re_q[0]) : AW1'(re_q[0]);
        g_im   = im_q[0][ACCW-1] ? -AW1'(im_q[0]) : AW1'(im_q[0]);
        g_sum  = AW2'(g_re) + AW2'(g_im);
        gate_c = g_sum < (AW2'(1) << (FFT + 16));
    end
`endif

    // Frame sequencing, correlation, CORDIC FSM and result strobe.
    always_comb begin
        state_d = state_q;
        fc_d    = (fc_q == FCW'(P - 1)) ? '0 : fc_q + FCW'(1);
        ph_d    = '0;
        k_d     = k_q;
        ch_d    = ch_q;
        it_d    = it_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        freq_d  = freq_q;
        pa_d    = pa_q;
        pb_d    = pb_q;
        xs      = x_q >>> it_q;
        ys      = y_q >>> it_q;
        cx      = CW'(nre);
        cy      = CW'(nim);
        z_n     = z_q;
        for (int c = 0; c < NSINK; c++) begin
            re_d[c]  = re_q[c];
            im_d[c]  = im_q[c];
            ang_d[c] = ang_q[c];
        end

        if (fc_q < FCW'(N)) begin
            ph_d = ph_q + k_q;
            for (int c = 0; c < NSINK; c++) begin
                re_d[c] = ((fc_q == '0) ? '0 : re_q[c]) + ACCW'(prod_re[c]);
                im_d[c] = ((fc_q == '0) ? '0 : im_q[c]) - ACCW'(prod_im[c]);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (fc_q == FCW'(N)) begin
                    state_d = S_LOAD;
                    ch_d    = '0;
                end
            end
            S_LOAD: begin
                // Pre-rotate left-half-plane vectors by -/+90 deg so CORDIC converges.
                if (cx[CW-1] && !cy[CW-1]) begin
                    x_d = cy;
                    y_d = -cx;
                    z_d = 16'h4000;
                end else if (cx[CW-1]) begin
                    x_d = -cy;
                    y_d = cx;
                    z_d = 16'hC000;
                end else begin
                    x_d = cx;
                    y_d = cy;
                    z_d = '0;
                end
                zero_d  = norm_zero;
                it_d    = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (!y_q[CW-1]) begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_n = z_q + atan_t[it_q];
                end else begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_n = z_q - atan_t[it_q];
                end
                z_d  = z_n;
                it_d = it_q + 4'd1;
                if (it_q == 4'd15) begin
                    ang_d[ch_q] = zero_q ? '0 : z_n;
                    if (ch_q == CHW'(NSINK - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        ch_d    = ch_q + CHW'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fc_q == FCW'(N + 63)) begin
            valid_d = 1'b1;
            sop_d   = (k_q == FFT'(KMIN));
            eop_d   = (k_q == FFT'(KMAX));
            freq_d  = 24'((64'(k_q) * 64'(CLK_HZ)) >> FFT);
            pa_d    = ang_q[1] - ang_q[0];
            if (NSINK >= 3) pb_d = ang_q[(NSINK >= 3) ? 2 : 0] - ang_q[0];
            else            pb_d = '0;
`ifdef PR3_MAG_GATE_EN
            if (gate_c) begin
                pa_d = '0;
                pb_d = '0;
            end
`endif
            k_d = (k_q == FFT'(KMAX)) ? FFT'(KMIN) : k_q + FFT'(1);
        end
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            fc_q    <= '0;
            ph_q    <= '0;
            k_q     <= FFT'(KMIN);
            ch_q    <= '0;
            it_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            freq_q  <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
            for (int c = 0; c < NSINK; c++) begin
                re_q[c]  <= '0;
                im_q[c]  <= '0;
                ang_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            ph_q    <= ph_d;
            k_q     <= k_d;
            ch_q    <= ch_d;
            it_q    <= it_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            freq_q  <= freq_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            for (int c = 0; c < NSINK; c++) begin
                re_q[c]  <= re_d[c];
                im_q[c]  <= im_d[c];
                ang_q[c] <= ang_d[c];
            end
        end
    end

    assign source_valid  = valid_q;
    assign source_sop    = sop_q;
    assign source_eop    = eop_q;
    assign source_freq   = freq_q;
    assign source_phaseA = pa_q;
    assign source_phaseB = pb_q;

endmodule

// File: tb/tb_pr3_phase_scanner.sv
// Directed bench for pr3_phase_scanner: reset, timing, bin sweep, tone phases, mid-frame reset.
module tb_pr3_phase_scanner;

    localparam int  NS    = 3;
    localparam int  W     = 14;
    localparam int  NFFT  = 2048;
    localparam int  P     = 8000;
    localparam int  FIRST = 2112;
    localparam real PI    = 3.14159265358979323846;

    logic                clk40 = 1'b0;
    logic                reset;
    logic signed [W-1:0] sink [NS];
    logic                source_valid, source_sop, source_eop;
    logic [23:0]         source_freq;
    logic [15:0]         source_phaseA, source_phaseB;

    int   checks = 0;
    int   errors = 0;
    int   n;
    int   mode;
    real  kt, phi1, phi2;
    int   ns;
    int   s_n    [16];
    logic [23:0] s_freq [16];
    logic [15:0] s_pa   [16];
    logic [15:0] s_pb   [16];
    logic        s_sop  [16];
    logic        s_eop  [16];
    logic        prev_v;
    logic [23:0] prev_f;
    int   freq_tab [8] = '{1953125, 1972656, 1992187, 2011718, 2031250, 2050781, 2070312, 2089843};

    pr3_phase_scanner dut (
        .clk40         (clk40),
        .reset         (reset),
        .sink          (sink),
        .source_valid  (source_valid),
        .source_sop    (source_sop),
        .source_eop    (source_eop),
        .source_freq   (source_freq),
        .source_phaseA (source_phaseA),
        .source_phaseB (source_phaseB)
    );

    always #12 clk40 = ~clk40;

    function automatic int wdiff(input logic [15:0] a, input int e);
        logic signed [15:0] t;
        t = $signed(a - 16'(e));
        return int'(t);
    endfunction

    task automatic drive_sample();
        int  m;
        real th;
        real v [NS];
        m = n % P;
        if (mode == 0) begin
            for (int c = 0; c < NS; c++) sink[c] = '0;
        end else begin
            th   = 2.0 * PI * kt * $itor(m) / $itor(NFFT);
            v[0] = 1000.0 * $cos(th);
            v[1] = 1000.0 * $cos(th + phi1 * PI / 180.0);
            v[2] = 1000.0 * $cos(th + phi2 * PI / 180.0);
            for (int c = 0; c < NS; c++) sink[c] = W'($rtoi(v[c] + ((v[c] >= 0.0) ? 0.5 : -0.5)));
        end
    endtask

    task automatic clear_records();
        ns     = 0;
        prev_v = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_n[i]    = -1;
            s_freq[i] = 'x;
            s_pa[i]   = 'x;
            s_pb[i]   = 'x;
            s_sop[i]  = 1'bx;
            s_eop[i]  = 1'bx;
        end
    endtask

    // Run a number of clocks from the current sample index, logging and timing every strobe.
    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive_sample();
            @(negedge clk40);
            n++;
            if (prev_v) begin
                checks++;
                if (source_valid !== 1'b0 || source_sop !== 1'b0 || source_eop !== 1'b0 || source_freq !== prev_f) begin
                    errors++;
                    $display("FAIL strobe_hold n=%0d valid=%b sop=%b eop=%b freq=%0d required 0 0 0 %0d",
                             n, source_valid, source_sop, source_eop, source_freq, prev_f);
                end
            end
            prev_v = (source_valid === 1'b1);
            if (prev_v) begin
                prev_f = source_freq;
                checks++;
                if (n % P != FIRST) begin
                    errors++;
                    $display("FAIL strobe_time n=%0d fc=%0d required fc=%0d", n, n % P, FIRST);
                end
                if (ns < 16) begin
                    s_n[ns]    = n;
                    s_freq[ns] = source_freq;
                    s_pa[ns]   = source_phaseA;
                    s_pb[ns]   = source_phaseB;
                    s_sop[ns]  = source_sop;
                    s_eop[ns]  = source_eop;
                end
                ns++;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mode  = 0;
        n     = 0;
        drive_sample();
        repeat (8) @(negedge clk40);
        clear_records();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mode  = 0;
        n     = 0;
        drive_sample();
        repeat (8) @(negedge clk40);
        checks += 6;
        if (source_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", source_valid); end
        if (source_sop !== 1'b0)   begin errors++; $display("FAIL reset_sop got %b required 0", source_sop); end
        if (source_eop !== 1'b0)   begin errors++; $display("FAIL reset_eop got %b required 0", source_eop); end
        if (source_freq !== 24'd0) begin errors++; $display("FAIL reset_freq got %0d required 0", source_freq); end
        if (source_phaseA !== 16'd0) begin errors++; $display("FAIL reset_phaseA got %0d required 0", source_phaseA); end
        if (source_phaseB !== 16'd0) begin errors++; $display("FAIL reset_phaseB got %0d required 0", source_phaseB); end
        reset = 1'b0;
    endtask

    task automatic test_zero_input();
        do_reset();
        mode = 0;
        run(FIRST + 1);
        checks += 6;
        if (ns != 1) begin errors++; $display("FAIL zero_count got %0d strobes required 1", ns); end
        if (s_freq[0] !== 24'd1953125) begin errors++; $display("FAIL zero_freq got %0d required 1953125", s_freq[0]); end
        if (s_sop[0] !== 1'b1) begin errors++; $display("FAIL zero_sop got %b required 1", s_sop[0]); end
        if (s_eop[0] !== 1'b0) begin errors++; $display("FAIL zero_eop got %b required 0", s_eop[0]); end
        if (s_pa[0] !== 16'd0) begin errors++; $display("FAIL zero_phaseA got %0d required 0", s_pa[0]); end
        if (s_pb[0] !== 16'd0) begin errors++; $display("FAIL zero_phaseB got %0d required 0", s_pb[0]); end
    endtask

    task automatic test_phase_offsets();
        int da, db;
        do_reset();
        mode = 1; kt = 100.0; phi1 = 45.0; phi2 = 120.0;
        run(FIRST + 1);
        da = wdiff(s_pa[0], 8192);
        db = wdiff(s_pb[0], 21845);
        checks += 4;
        if (ns != 1) begin errors++; $display("FAIL phase_count got %0d strobes required 1", ns); end
        if (s_sop[0] !== 1'b1) begin errors++; $display("FAIL phase_sop got %b required 1", s_sop[0]); end
        if (s_pa[0] === 16'hxxxx || da > 64 || da < -64) begin
            errors++; $display("FAIL phase_45 got %0d required 8192+/-64", $signed(s_pa[0]));
        end
        if (s_pb[0] === 16'hxxxx || db > 64 || db < -64) begin
            errors++; $display("FAIL phase_120 got %0d required 21845+/-64", $signed(s_pb[0]));
        end
    endtask

    task automatic test_identical();
        int da, db;
        do_reset();
        mode = 1; kt = 100.0; phi1 = 0.0; phi2 = 0.0;
        run(FIRST + 1);
        da = wdiff(s_pa[0], 0);
        db = wdiff(s_pb[0], 0);
        checks += 3;
        if (ns != 1) begin errors++; $display("FAIL ident_count got %0d strobes required 1", ns); end
        if (da > 64 || da < -64) begin errors++; $display("FAIL ident_phaseA got %0d required 0+/-64", $signed(s_pa[0])); end
        if (db > 64 || db < -64) begin errors++; $display("FAIL ident_phaseB got %0d required 0+/-64", $signed(s_pb[0])); end
    endtask

    // Nine frames with a bin-104 tone: freq sweep, sop/eop, wrap, and tone phases on k=104.
    task automatic test_sweep_tone();
        int da, db;
        do_reset();
        mode = 1; kt = 104.0; phi1 = -90.0; phi2 = 180.0;
        run(FIRST + 8 * P + 1);
        checks++;
        if (ns != 9) begin errors++; $display("FAIL sweep_count got %0d strobes required 9", ns); end
        for (int i = 0; i < 9; i++) begin
            checks += 3;
            if (s_freq[i] !== 24'(freq_tab[i % 8])) begin
                errors++; $display("FAIL sweep_freq idx=%0d got %0d required %0d", i, s_freq[i], freq_tab[i % 8]);
            end
            if (s_sop[i] !== ((i % 8) == 0)) begin
                errors++; $display("FAIL sweep_sop idx=%0d got %b required %b", i, s_sop[i], (i % 8) == 0);
            end
            if (s_eop[i] !== ((i % 8) == 7)) begin
                errors++; $display("FAIL sweep_eop idx=%0d got %b required %b", i, s_eop[i], (i % 8) == 7);
            end
        end
        da = wdiff(s_pa[4], -16384);
        db = wdiff(s_pb[4], 32768);
        checks += 2;
        if (s_pa[4] === 16'hxxxx || da > 64 || da < -64) begin
            errors++; $display("FAIL tone_phaseA got %0d required -16384+/-64", $signed(s_pa[4]));
        end
        if (s_pb[4] === 16'hxxxx || db > 65 || db < -65) begin
            errors++; $display("FAIL tone_phaseB got %0d required +/-32767+/-64", $signed(s_pb[4]));
        end
    endtask

    // Continues from the sweep (next pending bin is 101): reset at fc=1000 of the following frame.
    task automatic test_reset_mid_frame();
        mode = 0;
        run(9 * P + 1000 - n);
        checks++;
        if (ns != 9) begin errors++; $display("FAIL midrst_pre_count got %0d strobes required 9", ns); end
        reset = 1'b1;
        repeat (2) @(negedge clk40);
        checks += 2;
        if (source_freq !== 24'd0) begin errors++; $display("FAIL midrst_freq got %0d required 0", source_freq); end
        if (source_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b required 0", source_valid); end
        clear_records();
        n = 0;
        reset = 1'b0;
        run(FIRST + 1);
        checks += 3;
        if (ns != 1) begin errors++; $display("FAIL midrst_count got %0d strobes required 1", ns); end
        if (s_freq[0] !== 24'd1953125) begin errors++; $display("FAIL midrst_k got freq %0d required 1953125", s_freq[0]); end
        if (s_sop[0] !== 1'b1) begin errors++; $display("FAIL midrst_sop got %b required 1", s_sop[0]); end
    endtask

    initial begin
        reset = 1'b1;
        for (int c = 0; c < NS; c++) sink[c] = '0;
        test_reset();
        test_zero_input();
        test_phase_offsets();
        test_identical();
        test_sweep_tone();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
